// File: rtl/wb_mux_pkg.sv
// Shared types and constants for the Wishbone master mux and its watchdog.
package wb_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } mux_state_e;

    localparam int TO_CNT_W = 8;

    function automatic int wait_cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Wait counter for one slave access; flags the cycle in which the access has
// been pending for the full TIMEOUT window.
module wb_watchdog
    import wb_mux_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic wb_clk,
    input  logic wb_rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = wait_cnt_width(TIMEOUT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] base;

    // A clear and a tick in the same cycle start a new window that already
    // includes the current waiting cycle.
    always_comb begin
        base    = clear ? '0 : count_q;
        count_d = base + CW'(tick);
    end

    generate
        if (TIMEOUT == 0) begin : g_no_wd
            assign expired = 1'b0;
        end else begin : g_wd
            assign expired = tick & (base == CW'(TIMEOUT - 1));
        end
    endgenerate

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_master_mux.sv
// Routes the arbiter-granted Wishbone classic master to the shared slave port
// and aborts slave accesses that hang past TIMEOUT cycles.
module wb_master_mux
    import wb_mux_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int SEL_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst_n,
    input  logic [SEL_W-1:0]              arb_select,
    input  logic                          arb_active,
    input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
    input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]        wbm_we_i,
    input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
    output logic [DW-1:0]                 wbm_dat_o,
    output logic [NUM_MASTERS-1:0]        wbm_ack_o,
    output logic [NUM_MASTERS-1:0]        wbm_err_o,
    output logic [AW-1:0]                 wbs_adr_o,
    output logic [DW-1:0]                 wbs_dat_o,
    output logic [DW/8-1:0]               wbs_sel_o,
    output logic                          wbs_we_o,
    output logic                          wbs_cyc_o,
    output logic                          wbs_stb_o,
    input  logic [DW-1:0]                 wbs_dat_i,
    input  logic                          wbs_ack_i,
    input  logic                          wbs_err_i,
    output logic [TO_CNT_W-1:0]           timeout_count_o
);

    mux_state_e           state_q, state_d;
    logic [SEL_W-1:0]     sel_q;
    logic [TO_CNT_W-1:0]  tc_q, tc_d;

    logic [NUM_MASTERS-1:0] sel_oh;
    logic [AW-1:0]          adr_m;
    logic [DW-1:0]          dat_m;
    logic [DW/8-1:0]        bsel_m;
    logic                   we_m, cyc_m, stb_m;
    logic                   go, resp, tick, sel_changed;
    logic                   wd_clear, wd_expired;

    // Out-of-range select values decode to no master at all.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_dec
            assign sel_oh[gi] = (arb_select == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        adr_m  = '0;
        dat_m  = '0;
        bsel_m = '0;
        we_m   = 1'b0;
        cyc_m  = 1'b0;
        stb_m  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            adr_m  = adr_m  | ({AW{sel_oh[k]}}     & wbm_adr_i[k*AW +: AW]);
            dat_m  = dat_m  | ({DW{sel_oh[k]}}     & wbm_dat_i[k*DW +: DW]);
            bsel_m = bsel_m | ({(DW/8){sel_oh[k]}} & wbm_sel_i[k*(DW/8) +: DW/8]);
            we_m   = we_m   | (sel_oh[k] & wbm_we_i[k]);
            cyc_m  = cyc_m  | (sel_oh[k] & wbm_cyc_i[k]);
            stb_m  = stb_m  | (sel_oh[k] & wbm_stb_i[k]);
        end
    end

    assign go          = arb_active & cyc_m;
    assign sel_changed = (arb_select != sel_q);

    assign wbs_adr_o = adr_m;
    assign wbs_dat_o = dat_m;
    assign wbs_sel_o = bsel_m;
    assign wbs_we_o  = we_m;
    // Reset gating keeps the slave quiet while reset is held even if a master drives cyc.
    assign wbs_cyc_o = wb_rst_n & go & (state_q != ST_ABORT);
    assign wbs_stb_o = wbs_cyc_o & stb_m;

    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = sel_oh & {NUM_MASTERS{wbs_ack_i & wbs_stb_o}};
    assign wbm_err_o = sel_oh & {NUM_MASTERS{(wbs_err_i & wbs_stb_o) | (state_q == ST_ABORT)}};

    assign resp     = wbs_ack_i | wbs_err_i;
    assign tick     = wbs_stb_o & ~resp;
    assign wd_clear = (state_q != ST_BUSY) | ~go | sel_changed;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .clear    (wd_clear),
        .tick     (tick),
        .expired  (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = wd_expired ? ST_ABORT : ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A response on the limit cycle wins over the abort.
                if (!go || sel_changed) begin
                    state_d = ST_IDLE;
                end else if (wbs_stb_o && resp) begin
                    state_d = ST_IDLE;
                end else if (wd_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                if (tc_q != '1) begin
                    tc_d = tc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= arb_select;
            tc_q    <= tc_d;
        end
    end

    assign timeout_count_o = tc_q;

endmodule

// File: tb/tb_wb_master_mux.sv
// Self-checking bench for wb_master_mux with two masters and a 4-cycle watchdog.
module tb_wb_master_mux;

    localparam int NM  = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [0:0]      arb_select;
    logic            arb_active;
    logic [NM*AW-1:0] wbm_adr_i;
    logic [NM*DW-1:0] wbm_dat_i;
    logic [NM*DW/8-1:0] wbm_sel_i;
    logic [NM-1:0]   wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [DW-1:0]   wbm_dat_o;
    logic [NM-1:0]   wbm_ack_o, wbm_err_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [DW/8-1:0] wbs_sel_o;
    logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [DW-1:0]   wbs_dat_i;
    logic            wbs_ack_i, wbs_err_i;
    logic [7:0]      timeout_count_o;

    always #5 clk = ~clk;

    wb_master_mux #(
        .NUM_MASTERS (NM),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT     (TMO)
    ) dut (
        .wb_clk          (clk),
        .wb_rst_n        (rst_n),
        .arb_select      (arb_select),
        .arb_active      (arb_active),
        .wbm_adr_i       (wbm_adr_i),
        .wbm_dat_i       (wbm_dat_i),
        .wbm_sel_i       (wbm_sel_i),
        .wbm_we_i        (wbm_we_i),
        .wbm_cyc_i       (wbm_cyc_i),
        .wbm_stb_i       (wbm_stb_i),
        .wbm_dat_o       (wbm_dat_o),
        .wbm_ack_o       (wbm_ack_o),
        .wbm_err_o       (wbm_err_o),
        .wbs_adr_o       (wbs_adr_o),
        .wbs_dat_o       (wbs_dat_o),
        .wbs_sel_o       (wbs_sel_o),
        .wbs_we_o        (wbs_we_o),
        .wbs_cyc_o       (wbs_cyc_o),
        .wbs_stb_o       (wbs_stb_o),
        .wbs_dat_i       (wbs_dat_i),
        .wbs_ack_i       (wbs_ack_i),
        .wbs_err_i       (wbs_err_i),
        .timeout_count_o (timeout_count_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        arb_active = 1'b1;
        wbm_cyc_i  = '0;
        wbm_stb_i  = '0;
        wbs_ack_i  = 1'b0;
        wbs_err_i  = 1'b0;
    endtask

    // Single-cycle vectors that all leave the mux idle afterwards.
    typedef struct {
        logic        sel;
        logic        act;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        err;
        logic        exp_cyc;
        logic        exp_stb;
        logic [1:0]  exp_ack;
        logic [1:0]  exp_err;
        logic [31:0] exp_adr;
    } vec_t;

    vec_t vecs[7];

    // Directed multi-cycle transfer; -1 disables an event.
    task automatic directed(input string name, input int sel, input int len, input int ack_c,
                            input int err_c, input int drop_c, input int abort_c, input int exp_tc);
        logic [1:0] oh;
        oh = 2'b01 << sel;
        for (int c = 0; c < len; c++) begin
            arb_select = sel[0:0];
            arb_active = (c != drop_c);
            wbm_cyc_i  = oh;
            wbm_stb_i  = oh;
            wbs_ack_i  = (c == ack_c);
            wbs_err_i  = (c == err_c);
            @(negedge clk);
            chk({name, " cyc"}, wbs_cyc_o, !(c == drop_c || c == abort_c));
            chk({name, " ack"}, wbm_ack_o, (c == ack_c) ? oh : 2'b00);
            chk({name, " err"}, wbm_err_o, (c == err_c || c == abort_c) ? oh : 2'b00);
            if (c == ack_c) chk({name, " rdata"}, wbm_dat_o, 32'hDEADBEEF);
            if (c == 0)     chk({name, " adr"}, wbs_adr_o, sel ? 32'h100 : 32'hA0);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(posedge clk);
        #1;
        chk({name, " timeout_count"}, timeout_count_o, exp_tc);
        $display("seq %s: timeout_count=%0d", name, timeout_count_o);
    endtask

    // Reference model: counts consecutive waiting cycles of the granted master.
    int  m_waited;
    bit  m_abort;
    int  m_tc;
    int  m_prev_sel;

    task automatic rand_step();
        int  m;
        bit  go, ecyc, estb;
        logic [1:0] eack, eerr;
        if ($urandom_range(7) == 0) arb_select = ~arb_select;
        arb_active = ($urandom_range(7) != 0);
        for (int k = 0; k < NM; k++) begin
            wbm_cyc_i[k] = ($urandom_range(5) != 0);
            wbm_stb_i[k] = ($urandom_range(3) != 0);
            wbm_we_i[k]  = $urandom_range(1);
        end
        wbm_adr_i = {$urandom, $urandom};
        wbm_dat_i = {$urandom, $urandom};
        wbm_sel_i = 8'($urandom);
        wbs_dat_i = $urandom;
        wbs_ack_i = ($urandom_range(4) == 0);
        wbs_err_i = ($urandom_range(15) == 0);

        m  = int'(arb_select);
        go = arb_active && wbm_cyc_i[m];
        if (m_abort) begin
            ecyc = 0; estb = 0; eack = 2'b00; eerr = 2'b01 << m;
        end else begin
            ecyc = go;
            estb = go && wbm_stb_i[m];
            eack = (wbs_ack_i && estb) ? (2'b01 << m) : 2'b00;
            eerr = (wbs_err_i && estb) ? (2'b01 << m) : 2'b00;
        end

        @(negedge clk);
        chk("rnd cyc", wbs_cyc_o, ecyc);
        chk("rnd stb", wbs_stb_o, estb);
        chk("rnd ack", wbm_ack_o, eack);
        chk("rnd err", wbm_err_o, eerr);
        chk("rnd adr", wbs_adr_o, wbm_adr_i[m*AW +: AW]);
        chk("rnd wdat", wbs_dat_o, wbm_dat_i[m*DW +: DW]);
        chk("rnd bsel", wbs_sel_o, wbm_sel_i[m*4 +: 4]);
        chk("rnd we", wbs_we_o, wbm_we_i[m]);
        chk("rnd rdat", wbm_dat_o, wbs_dat_i);
        chk("rnd timeout_count", timeout_count_o, m_tc);

        @(posedge clk);
        if (m_abort) begin
            m_abort  = 0;
            m_waited = 0;
            if (m_tc < 255) m_tc++;
        end else if (!go || (m_waited > 0 && m != m_prev_sel)) begin
            m_waited = 0;
        end else if (estb && (wbs_ack_i || wbs_err_i)) begin
            m_waited = 0;
        end else if (estb) begin
            if (m_waited == TMO - 1) begin
                m_abort  = 1;
                m_waited = 0;
            end else begin
                m_waited++;
            end
        end
        m_prev_sel = m;
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 32'hA0};
        vecs[1] = '{1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 32'h100};
        vecs[2] = '{1'b1, 1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'h100};
        vecs[3] = '{1'b0, 1'b1, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'hA0};
        vecs[4] = '{1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 32'hA0};
        vecs[5] = '{1'b1, 1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b10, 32'h100};
        vecs[6] = '{1'b0, 1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 32'hA0};

        wbm_adr_i  = {32'h100, 32'hA0};
        wbm_dat_i  = {32'h2222_2222, 32'h1111_1111};
        wbm_sel_i  = 8'hC3;
        wbm_we_i   = 2'b01;
        wbs_dat_i  = 32'hDEADBEEF;

        // Reset values, with a master actively requesting the bus.
        rst_n      = 1'b0;
        arb_select = 1'b0;
        arb_active = 1'b1;
        wbm_cyc_i  = 2'b01;
        wbm_stb_i  = 2'b01;
        wbs_ack_i  = 1'b1;
        wbs_err_i  = 1'b1;
        #2;
        chk("reset cyc", wbs_cyc_o, 1'b0);
        chk("reset stb", wbs_stb_o, 1'b0);
        chk("reset ack", wbm_ack_o, 2'b00);
        chk("reset err", wbm_err_o, 2'b00);
        chk("reset timeout_count", timeout_count_o, 8'd0);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            arb_select = vecs[i].sel;
            arb_active = vecs[i].act;
            wbm_cyc_i  = vecs[i].cyc;
            wbm_stb_i  = vecs[i].stb;
            wbs_ack_i  = vecs[i].ack;
            wbs_err_i  = vecs[i].err;
            @(negedge clk);
            chk($sformatf("vec%0d cyc", i), wbs_cyc_o, vecs[i].exp_cyc);
            chk($sformatf("vec%0d stb", i), wbs_stb_o, vecs[i].exp_stb);
            chk($sformatf("vec%0d ack", i), wbm_ack_o, vecs[i].exp_ack);
            chk($sformatf("vec%0d err", i), wbm_err_o, vecs[i].exp_err);
            chk($sformatf("vec%0d adr", i), wbs_adr_o, vecs[i].exp_adr);
            $display("vec %0d: sel=%0d act=%0b ack_o=%b err_o=%b", i, vecs[i].sel, vecs[i].act,
                     wbm_ack_o, wbm_err_o);
            @(posedge clk);
            #1;
        end
        idle_inputs();
        @(posedge clk);
        #1;

        //        name             sel len ack err drop abort tc
        directed("read_m1",        1,  3,  2, -1, -1,  -1,   0);
        directed("hung_slave",     0,  5, -1, -1, -1,   4,   1);
        directed("ack_on_limit",   0,  5,  3, -1, -1,  -1,   1);
        directed("slave_err",      0,  3, -1,  1, -1,  -1,   1);
        directed("grant_withdrawn",0,  8, -1, -1,  2,   7,   2);

        // Reset while waiting; the next hung transfer gets a full window.
        arb_select = 1'b0;
        arb_active = 1'b1;
        wbm_cyc_i  = 2'b01;
        wbm_stb_i  = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_reset pre cyc", wbs_cyc_o, 1'b1);
            chk("mid_reset pre err", wbm_err_o, 2'b00);
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        wbs_err_i = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("mid_reset cyc", wbs_cyc_o, 1'b0);
        chk("mid_reset stb", wbs_stb_o, 1'b0);
        chk("mid_reset ack", wbm_ack_o, 2'b00);
        chk("mid_reset err", wbm_err_o, 2'b00);
        chk("mid_reset timeout_count", timeout_count_o, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        wbs_err_i = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("after_reset cyc", wbs_cyc_o, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("after_reset c%0d err", c), wbm_err_o, (c == 4) ? 2'b01 : 2'b00);
            chk($sformatf("after_reset c%0d cyc", c), wbs_cyc_o, (c == 4) ? 1'b0 : 1'b1);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        chk("after_reset timeout_count", timeout_count_o, 8'd1);
        $display("seq mid_reset: timeout_count=%0d", timeout_count_o);

        // Randomized traffic against the reference model from a fresh reset.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        m_waited   = 0;
        m_abort    = 0;
        m_tc       = 0;
        m_prev_sel = 0;
        arb_select = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rand_step();
        end
        $display("random: %0d cycles, model timeout_count=%0d", 600, m_tc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_master_mux.md
# wb_master_mux

Downstream companion to the round-robin `arbiter`. It consumes the arbiter's `select`/`active` outputs and routes the granted Wishbone classic master onto the single shared slave port. It returns `ack`/`err` and read data to the granted master only. A per-transfer watchdog aborts any slave access that hangs past `TIMEOUT` cycles and reports the abort to the master as a bus error.

## Interface
- `NUM_MASTERS`, default 2: number of master ports; must be ≥1.
- `SEL_W`, default `NUM_MASTERS>1 ? $clog2(NUM_MASTERS) : 1`: width of the select input.
- `AW`, default 32: address width.
- `DW`, default 32: data width; `DW/8` byte selects.
- `TIMEOUT`, default 16: watchdog limit in cycles. 0 disables the watchdog.
- `wb_clk  in  1`: single clock, all state on rising edge.
- `wb_rst_n  in  1`: reset, asynchronous, active-low.
- `arb_select  in  SEL_W`: granted master index, from arbiter `select`.
- `arb_active  in  1`: grant valid, from arbiter `active`.
- `wbm_adr_i  in  NUM_MASTERS*AW`: master addresses, master k at `[k*AW +: AW]`.
- `wbm_dat_i  in  NUM_MASTERS*DW`: master write data, packed the same way.
- `wbm_sel_i  in  NUM_MASTERS*DW/8`: master byte selects.
- `wbm_we_i`, `wbm_cyc_i`, `wbm_stb_i`  `in  NUM_MASTERS`: one bit per master.
- `wbm_dat_o  out  DW`: read data, broadcast to all masters.
- `wbm_ack_o`, `wbm_err_o`  `out  NUM_MASTERS`: one-hot responses.
- `wbs_adr_o  out  AW`, `wbs_dat_o  out  DW`, `wbs_sel_o  out  DW/8`: slave request fields.
- `wbs_we_o`, `wbs_cyc_o`, `wbs_stb_o`  `out  1`: slave control.
- `wbs_dat_i  in  DW`, `wbs_ack_i  in  1`, `wbs_err_i  in  1`: slave response.
- `timeout_count_o  out  8`: saturating count of watchdog aborts.

## Operation
- Let `m = arb_select` and `go = arb_active & wbm_cyc_i[m]`.
- **Forward path** (combinational):
  - `wbs_adr/dat/sel/we_o` are master m's fields.
  - `wbs_cyc_o = go & (state!=ABORT)`.
  - `wbs_stb_o = wbs_cyc_o & wbm_stb_i[m]`.
- **Return path** (combinational):
  - `wbm_dat_o = wbs_dat_i`.
  - `wbm_ack_o[m] = wbs_ack_i & wbs_stb_o`.
  - `wbm_err_o[m] = (wbs_err_i & wbs_stb_o) | (state==ABORT)`.
  - All non-granted bits are 0.
- **FSM states:** IDLE, BUSY, ABORT.
  - **IDLE:** goes to BUSY when `wbs_stb_o` is high and there is no ack/err; the wait counter is cleared.
  - **BUSY:** the counter increments each cycle with `wbs_stb_o` high and no ack/err.
    - Ack or err → IDLE.
    - `go` low or `arb_select` changed → IDLE, counter cleared, no error.
    - Counter reaching `TIMEOUT-1` with no response → ABORT.
  - **ABORT:** lasts exactly one cycle.
    - `wbs_cyc_o`/`wbs_stb_o` forced low.
    - `wbm_err_o[m]` high.
    - `timeout_count_o` increments, saturating at 255.
    - Then → IDLE.
    - A `wbs_ack_i` arriving during ABORT is ignored.
- **`TIMEOUT==0`:** the FSM never leaves IDLE/BUSY and the block is a pure mux.
- **Simultaneous events:** a slave ack in the same cycle the counter hits its limit wins; the FSM returns to IDLE and no abort occurs.

## Timing
- Forward and return paths: zero latency.
- Watchdog: `stb` first high in cycle 0 with no response through cycle `TIMEOUT-1` → abort error in cycle `TIMEOUT`.
- Back-to-back transfers: the FSM re-enters BUSY in the cycle after an ack if `stb` stays high, with the counter restarting at 0.
- Reset values (asynchronous, on `wb_rst_n` low):
  - state = IDLE.
  - counter = 0.
  - `timeout_count_o` = 0.
  - All `wbm_ack_o`/`wbm_err_o` = 0.
  - `wbs_cyc_o`/`wbs_stb_o` = 0 even if `go` is high.
- Reset mid-transfer: the transfer is abandoned with no error reported. After release, the first rising edge evaluates from IDLE.
- Counter width: `$clog2(TIMEOUT+1)`, minimum 1.

## Structure
- Package `wb_mux_pkg`: FSM state typedef (IDLE/BUSY/ABORT) and the 8-bit `timeout_count_o` width constant.
- Sub-module `wb_watchdog`: contains the wait counter and the limit compare.
  - Inputs: `wb_clk`, `wb_rst_n`, `clear`, `tick`.
  - Output: `expired`.
- The forward/return muxing and the FSM live in `wb_master_mux`.

## Test plan
All cases use `NUM_MASTERS=2`, `TIMEOUT=4`.
- **Read, granted master 1:** select=1, active=1, cyc/stb[1]=1, adr=0x100, slave acks in cycle 2 with dat=0xDEADBEEF → `wbm_ack_o=2'b10` in cycle 2, `wbm_dat_o=0xDEADBEEF`, `wbm_ack_o[0]=0` throughout.
- **Hung slave:** master 0 stb high from cycle 0, no ack → `wbm_err_o=2'b01` in cycle 4, `wbs_cyc_o=0` in cycle 4, `timeout_count_o=1` afterwards.
- **Ack on limit cycle:** ack in cycle 3 → ack delivered, no err, `timeout_count_o` unchanged.
- **Slave error passthrough:** `wbs_err_i` in cycle 1 → `wbm_err_o[m]` in cycle 1, FSM back to IDLE, counter not incremented.
- **Grant withdrawn:** `arb_active` drops in cycle 2 of a transfer → `wbs_cyc_o=0` the same cycle, no err, next transfer gets a full 4-cycle window.
- **Mid-transfer reset:** `wb_rst_n` low during BUSY counter=2 → all outputs 0 immediately; after release a hung transfer times out 4 cycles later, not 2.
